or_tree_pipe: RTL and testbench
===============================

Name: or_tree_pipe

Overview:
- Parametrised, pipelined N-input OR reduction for the schematic macro library; next generation of the fixed-width combinational OR gate macros.
- Splits the reduction into a registered tree of LEAF-input OR levels so wide reductions close timing.
- Carries a valid flag and the lowest asserted input index alongside the result.
- Optional sticky mode latches any hit until software clears it; intended for error/interrupt aggregation.

Parameters:
WIDTH, 10, number of OR inputs (2..256)
LEAF, 4, fan-in per tree level (2..8)
STICKY, 0, 0 = Z0 follows pipeline result; 1 = Z0/FIRST latch first hit until SCLR
IW, clog2(WIDTH), width of FIRST (derived, not overridable)

Ports:
CK  input  1  clock, rising edge
CD  input  1  asynchronous clear, active-high
CE  input  1  clock enable for pipeline and result registers
SCLR  input  1  synchronous clear of sticky state (STICKY=1 only, ignored otherwise)
VI  input  1  input sample valid
A  input  WIDTH  OR inputs, bit 0 = lowest index
VO  output  1  result valid
Z0  output  1  OR of sampled A (or sticky hit)
FIRST  output  IW  lowest index i with A[i]=1 in the reported sample

Behaviour:
- Interface: one clock CK; CD is asynchronous and active-high.
- Levels LAT = 1 if WIDTH<=LEAF, else ceil(log_LEAF(WIDTH)); WIDTH=10, LEAF=4 gives LAT=2; WIDTH=64, LEAF=4 gives LAT=3.
- Each level registers its partial ORs, the valid bit and partial min-index.
- Group g of a level covers consecutive lower-level nodes g*LEAF..g*LEAF+LEAF-1; a short last group ORs only existing nodes.
- Index merge per group: lowest-numbered child with hit supplies the index. If no child hits, index is 0.
- Latency: A/VI sampled on a CK edge with CE=1 appear on Z0/FIRST/VO exactly LAT CE-qualified edges later.
- CE=0: every pipeline register, VO, Z0 and FIRST hold; no data lost or duplicated.
- VI=0 samples propagate as bubbles: VO=0; in STICKY=0, Z0=0 and FIRST=0 for that slot.
- STICKY=0: Z0/FIRST are the registered last-level values, qualified by VO as above.
- STICKY=1:
  - On an edge with CE=1 where the last level presents a valid hit: if Z0 was 0, Z0 becomes 1 and FIRST captures that index. If Z0 was already 1, FIRST is unchanged.
  - VO pulses with each valid sample regardless of hit.
- SCLR (STICKY=1):
  - Acts on any CK edge independent of CE; clears Z0 and FIRST.
  - Does not flush in-flight pipeline data.
  - SCLR and a valid hit on the same edge with CE=1: the hit wins. Z0=1 and FIRST takes the new index.
- CD asserted at any time: all pipeline registers, VO, Z0, FIRST go to 0 immediately; in-flight samples discarded.
- First sample after CD release emerges LAT edges later.
- All-zero A with VI=1: VO=1, Z0=0, FIRST=0. FIRST=0 with Z0=1 means bit 0 hit.
- No X propagation: unused tree slots tie to 0.

Test Plan:
1. WIDTH=10, LEAF=4, STICKY=0. VI=1, A=10'h000, then 10'h200, then 10'h048 on consecutive CE=1 edges -> from edge 2 on: (VO,Z0,FIRST) = (1,0,0), (1,1,9), (1,1,3).
2. Same config. A=10'h001 with VI=1, then CE=0 for 3 cycles -> result holds invisible during stall; after CE returns it appears 2 CE edges after sampling as Z0=1, FIRST=0; VO asserts exactly once.
3. STICKY=1. Samples A=10'h010, then 10'h002, then 10'h000 -> Z0 rises with FIRST=4 and stays 1; FIRST stays 4. Then SCLR pulse with no hit in flight -> Z0=0, FIRST=0 on next edge.
4. STICKY=1. SCLR asserted on the same edge the last level presents A=10'h100 -> Z0=1, FIRST=8 after that edge. Separately, SCLR with CE=0 still clears Z0 to 0.
5. CD asserted mid-stream with two samples in flight (10'h3FF, 10'h020) -> VO/Z0/FIRST=0 asynchronously; after release with VI=0, VO stays 0 for 3+ cycles.
6. WIDTH=64, LEAF=4, random VI/A/CE for 10k cycles -> scoreboard checks Z0=|A and FIRST=lowest set bit of A, each 3 CE edges later; covers A=0, A[63] only, A[0] only.

Source files
------------

// File: rtl/or_tree_pipe.sv
// or_tree_pipe: pipelined N-input OR reduction.
// The reduction is built as a registered tree of LEAF-input OR nodes.
// Each node also carries the lowest asserted input index of its subtree.
// A valid bit travels through the tree alongside the data.
// With STICKY=1, the result register latches the first hit until SCLR.
module or_tree_pipe #(
    parameter int WIDTH  = 10,
    parameter int LEAF   = 4,
    parameter int STICKY = 0,
    localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          CK,
    input  logic          CD,
    input  logic          CE,
    input  logic          SCLR,
    input  logic          VI,
    input  logic [WIDTH-1:0] A,
    output logic          VO,
    output logic          Z0,
    output logic [IW-1:0] FIRST
);

    // Number of tree levels. A single level is used even when WIDTH <= LEAF.
    function automatic int calc_lat(input int w, input int leaf);
        int n;
        int l;
        n = (w + leaf - 1) / leaf;
        l = 1;
        while (n > 1) begin
            n = (n + leaf - 1) / leaf;
            l++;
        end
        return l;
    endfunction

    // Number of nodes feeding level lvl. Level 0 is fed by the raw inputs.
    function automatic int level_nodes(input int lvl);
        int n;
        n = WIDTH;
        for (int i = 0; i < lvl; i++) begin
            n = (n + LEAF - 1) / LEAF;
        end
        return n;
    endfunction

    // Offset of level lvl's input nodes within the flat node bus.
    function automatic int level_off(input int lvl);
        int o;
        o = 0;
        for (int i = 0; i < lvl; i++) begin
            o += level_nodes(i);
        end
        return o;
    endfunction

    localparam int LAT   = calc_lat(WIDTH, LEAF);
    localparam int BUS_N = level_off(LAT);

    // Flat node bus, laid out as follows:
    //   - Entries 0..WIDTH-1 are the qualified inputs.
    //   - These are followed by the registered outputs of each non-final level.
    //   - The final level feeds the result register directly.
    logic            hit_bus [BUS_N];
    logic [IW-1:0]   idx_bus [BUS_N];
    logic [LAT:0]    valid_bus;

    logic            last_hit;
    logic [IW-1:0]   last_idx;
    logic            z0_reg;
    logic [IW-1:0]   first_reg;

    genvar gi;
    genvar gj;

    // Leaf inputs are gated by VI, so a bubble carries no hit and index 0 through the tree.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_in
            assign hit_bus[gi] = A[gi] & VI;
            assign idx_bus[gi] = IW'(gi);
        end
    endgenerate

    assign valid_bus[0] = VI;

    generate
        for (gi = 0; gi < LAT; gi++) begin : g_lvl
            localparam int NIN    = level_nodes(gi);
            localparam int NOUT   = level_nodes(gi + 1);
            localparam int IN_OFF = level_off(gi);

            logic valid_reg;

            // Valid bit advances one level per enabled edge.
            always_ff @(posedge CK or posedge CD) begin
                if (CD) begin
                    valid_reg <= 1'b0;
                end else if (CE) begin
                    valid_reg <= valid_bus[gi];
                end
            end

            assign valid_bus[gi + 1] = valid_reg;

            for (gj = 0; gj < NOUT; gj++) begin : g_node
                localparam int BASE = IN_OFF + gj * LEAF;
                // The last group of a level may have fewer than LEAF children.
                localparam int NCH  = (NIN - gj * LEAF < LEAF) ? (NIN - gj * LEAF) : LEAF;

                logic          hit_next;
                logic [IW-1:0] idx_next;

                // OR the children together. Scanning from high to low lets the lowest hit child supply the index.
                always_comb begin
                    hit_next = 1'b0;
                    idx_next = '0;
                    for (int c = NCH - 1; c >= 0; c--) begin
                        if (hit_bus[BASE + c]) begin
                            hit_next = 1'b1;
                            idx_next = idx_bus[BASE + c];
                        end
                    end
                end

                if (gi < LAT - 1) begin : g_reg
                    logic          hit_reg;
                    logic [IW-1:0] idx_reg;

                    // Pipeline register for this partial OR and its min-index.
                    always_ff @(posedge CK or posedge CD) begin
                        if (CD) begin
                            hit_reg <= 1'b0;
                            idx_reg <= '0;
                        end else if (CE) begin
                            hit_reg <= hit_next;
                            idx_reg <= idx_next;
                        end
                    end

                    assign hit_bus[level_off(gi + 1) + gj] = hit_reg;
                    assign idx_bus[level_off(gi + 1) + gj] = idx_reg;
                end else begin : g_last
                    assign last_hit = hit_next;
                    assign last_idx = idx_next;
                end
            end
        end
    endgenerate

    // Result register. Its behaviour depends on STICKY:
    //   - STICKY=0: plain final pipeline stage.
    //   - STICKY=1: capture the first hit and hold it until SCLR.
    // With STICKY=1, a new hit on the same edge as SCLR wins over the clear.
    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            z0_reg    <= 1'b0;
            first_reg <= '0;
        end else if (STICKY == 0) begin
            if (CE) begin
                z0_reg    <= last_hit;
                first_reg <= last_idx;
            end
        end else begin
            if (CE && last_hit) begin
                z0_reg <= 1'b1;
                if (!z0_reg || SCLR) begin
                    first_reg <= last_idx;
                end
            end else if (SCLR) begin
                z0_reg    <= 1'b0;
                first_reg <= '0;
            end
        end
    end

    assign VO    = valid_bus[LAT];
    assign Z0    = z0_reg;
    assign FIRST = first_reg;

endmodule

// File: tb/tb_or_tree_pipe.sv
// Testbench for or_tree_pipe. Three instances are exercised:
//   - WIDTH=10 non-sticky (u0)
//   - WIDTH=10 sticky (u1)
//   - WIDTH=64 non-sticky (u2), driven by random stimulus against a reference model.
module tb_or_tree_pipe;

    logic        CK = 1'b0;
    logic        CD;
    logic        CE;
    logic        SCLR;
    logic        VI;
    logic [9:0]  a10;
    logic [63:0] a64;

    logic        vo0, z00;
    logic [3:0]  f0;
    logic        vo1, z01;
    logic [3:0]  f1;
    logic        vo2, z02;
    logic [5:0]  f2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CK = ~CK;

    or_tree_pipe #(.WIDTH(10), .LEAF(4), .STICKY(0)) u0 (
        .CK(CK), .CD(CD), .CE(CE), .SCLR(SCLR), .VI(VI), .A(a10),
        .VO(vo0), .Z0(z00), .FIRST(f0)
    );

    or_tree_pipe #(.WIDTH(10), .LEAF(4), .STICKY(1)) u1 (
        .CK(CK), .CD(CD), .CE(CE), .SCLR(SCLR), .VI(VI), .A(a10),
        .VO(vo1), .Z0(z01), .FIRST(f1)
    );

    or_tree_pipe #(.WIDTH(64), .LEAF(4), .STICKY(0)) u2 (
        .CK(CK), .CD(CD), .CE(CE), .SCLR(SCLR), .VI(VI), .A(a64),
        .VO(vo2), .Z0(z02), .FIRST(f2)
    );

    typedef struct {
        logic       vi;
        logic [9:0] a;
        logic       vo;
        logic       z0;
        logic [3:0] first;
    } vec_t;

    typedef struct {
        logic       vo;
        logic       z0;
        logic [5:0] first;
    } exp_t;

    vec_t tbl [10];
    exp_t q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        @(negedge CK);
    endtask

    // Reference result for one sample: the OR of A and the position of its lowest set bit.
    function automatic exp_t ref_of(input logic vi, input logic [63:0] a);
        exp_t e;
        e.vo    = vi;
        e.z0    = 1'b0;
        e.first = '0;
        if (vi && (a != 64'd0)) begin
            e.z0 = 1'b1;
            for (int i = 63; i >= 0; i--) begin
                if (a[i]) e.first = 6'(i);
            end
        end
        return e;
    endfunction

    function automatic logic [63:0] rand_a64();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'd0;
            1:       v = 64'h8000_0000_0000_0000;
            2:       v = 64'd1;
            3:       v = {$urandom, $urandom};
            4:       v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            default: v = 64'd1 << $urandom_range(0, 63);
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   vo_cnt;
        exp_t e;
        logic [9:0]  s3_a  [5];
        logic        s3_vi [5];
        logic        s3_vo [5];
        logic        s3_z0 [5];
        logic [3:0]  s3_f  [5];

        // Each record lists a sample and the result it must produce LAT=2 edges later.
        tbl[0] = '{1'b1, 10'h000, 1'b1, 1'b0, 4'd0};
        tbl[1] = '{1'b1, 10'h200, 1'b1, 1'b1, 4'd9};
        tbl[2] = '{1'b1, 10'h048, 1'b1, 1'b1, 4'd3};
        tbl[3] = '{1'b1, 10'h001, 1'b1, 1'b1, 4'd0};
        tbl[4] = '{1'b0, 10'h3FF, 1'b0, 1'b0, 4'd0};
        tbl[5] = '{1'b1, 10'h3FF, 1'b1, 1'b1, 4'd0};
        tbl[6] = '{1'b1, 10'h300, 1'b1, 1'b1, 4'd8};
        tbl[7] = '{1'b1, 10'h080, 1'b1, 1'b1, 4'd7};
        tbl[8] = '{1'b1, 10'h030, 1'b1, 1'b1, 4'd4};
        tbl[9] = '{1'b1, 10'h00C, 1'b1, 1'b1, 4'd2};

        CD = 1'b1; CE = 1'b0; SCLR = 1'b0; VI = 1'b0; a10 = '0; a64 = '0;
        repeat (2) @(negedge CK);

        // Reset state
        chk("rst_vo0", vo0, 0); chk("rst_z00", z00, 0); chk("rst_f0", f0, 0);
        chk("rst_z01", z01, 0); chk("rst_f1", f1, 0);
        chk("rst_vo2", vo2, 0); chk("rst_z02", z02, 0); chk("rst_f2", f2, 0);
        $display("reset: vo0=%0b z00=%0b f0=%0d z01=%0b vo2=%0b", vo0, z00, f0, z01, vo2);

        CD = 1'b0; CE = 1'b1;
        tick(); tick();

        // Table-driven vectors through the WIDTH=10 non-sticky instance
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) begin
                VI = tbl[k].vi; a10 = tbl[k].a;
            end else begin
                VI = 1'b0; a10 = '0;
            end
            tick();
            if (k >= 1) begin
                chk("t1_vo", vo0, tbl[k-1].vo);
                chk("t1_z0", z00, tbl[k-1].z0);
                chk("t1_first", f0, tbl[k-1].first);
                $display("vec %0d: a=%h vi=%0b -> vo=%0b z0=%0b first=%0d",
                         k - 1, tbl[k-1].a, tbl[k-1].vi, vo0, z00, f0);
            end
        end

        // CE stall: one sample held in flight while CE=0 for three cycles
        vo_cnt = 0;
        VI = 1'b1; a10 = 10'h001; tick();
        chk("t2_vo_pre", vo0, 0); vo_cnt += int'(vo0);
        VI = 1'b0; a10 = '0; CE = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("t2_vo_stall", vo0, 0); vo_cnt += int'(vo0);
        end
        CE = 1'b1; tick();
        chk("t2_vo", vo0, 1); chk("t2_z0", z00, 1); chk("t2_first", f0, 0);
        vo_cnt += int'(vo0);
        tick();
        chk("t2_vo_post", vo0, 0); vo_cnt += int'(vo0);
        chk("t2_vo_count", vo_cnt, 1);
        $display("stall: vo pulses=%0d", vo_cnt);

        // Sticky: first hit latched, later hits ignored, then SCLR clears
        SCLR = 1'b1; VI = 1'b0; tick(); tick(); SCLR = 1'b0;
        chk("t3_clr0_z0", z01, 0); chk("t3_clr0_first", f1, 0);
        s3_a  = '{10'h010, 10'h002, 10'h000, 10'h000, 10'h000};
        s3_vi = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        s3_vo = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        s3_z0 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        s3_f  = '{4'd0, 4'd4, 4'd4, 4'd4, 4'd4};
        for (int s = 0; s < 5; s++) begin
            VI = s3_vi[s]; a10 = s3_a[s];
            tick();
            chk("t3_vo", vo1, s3_vo[s]);
            chk("t3_z0", z01, s3_z0[s]);
            chk("t3_first", f1, s3_f[s]);
            $display("sticky %0d: a=%h vi=%0b -> vo=%0b z0=%0b first=%0d",
                     s, s3_a[s], s3_vi[s], vo1, z01, f1);
        end
        SCLR = 1'b1; tick(); SCLR = 1'b0;
        chk("t3_sclr_z0", z01, 0); chk("t3_sclr_first", f1, 0);
        $display("sclr: z0=%0b first=%0d", z01, f1);

        // SCLR colliding with a hit: the hit wins and FIRST takes the new index
        VI = 1'b1; a10 = 10'h010; tick();
        chk("t4_pre_z0", z01, 0);
        a10 = 10'h100; tick();
        chk("t4_hit_z0", z01, 1); chk("t4_hit_first", f1, 4);
        VI = 1'b0; a10 = '0; SCLR = 1'b1; tick();
        chk("t4_win_z0", z01, 1); chk("t4_win_first", f1, 8);
        SCLR = 1'b0; tick();
        chk("t4_hold_z0", z01, 1); chk("t4_hold_first", f1, 8);
        CE = 1'b0; SCLR = 1'b1; tick();
        chk("t4_ce0_z0", z01, 0); chk("t4_ce0_first", f1, 0);
        SCLR = 1'b0; CE = 1'b1;
        $display("sclr vs hit: done, z0=%0b first=%0d", z01, f1);

        // Asynchronous clear with two samples in flight
        VI = 1'b1; a10 = 10'h3FF; tick();
        a10 = 10'h020; tick();
        VI = 1'b0; a10 = '0;
        chk("t5_pre_vo", vo0, 1); chk("t5_pre_z0", z00, 1); chk("t5_pre_z01", z01, 1);
        #1 CD = 1'b1;
        #1;
        chk("t5_cd_vo", vo0, 0); chk("t5_cd_z0", z00, 0); chk("t5_cd_first", f0, 0);
        chk("t5_cd_z01", z01, 0); chk("t5_cd_f1", f1, 0);
        @(negedge CK); CD = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tick();
            chk("t5_post_vo", vo0, 0); chk("t5_post_z0", z00, 0);
        end
        $display("async clear: vo=%0b z0=%0b", vo0, z00);

        // Random stimulus on the WIDTH=64 instance against the reference model
        q.delete();
        q.push_back(ref_of(1'b0, 64'd0));
        q.push_back(ref_of(1'b0, 64'd0));
        for (int n = 0; n < 10000; n++) begin
            CE  = ($urandom_range(0, 3) != 0);
            VI  = ($urandom_range(0, 3) != 0);
            a64 = rand_a64();
            @(posedge CK);
            if (CE) begin
                q.push_back(ref_of(VI, a64));
                if (q.size() > 3) void'(q.pop_front());
            end
            @(negedge CK);
            e = q[0];
            chk("rnd_vo", vo2, e.vo);
            chk("rnd_z0", z02, e.z0);
            chk("rnd_first", f2, e.first);
            $display("rnd %0d: ce=%0b vi=%0b a=%h -> vo=%0b z0=%0b first=%0d",
                     n, CE, VI, a64, vo2, z02, f2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
